touch_scan_sequencer: RTL

//  Time-multiplexed scan controller for the capacitive-touch pads on the uio pins.

---
 rtl/touch_scan_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/touch_scan_sequencer.sv
// Capacitive-touch scan sequencer. Charges, releases and times one pad at a
// time using a single shared counter. It keeps a per-pad baseline from the
// first sweep and derives a hysteretic touched flag for each pad.
module touch_scan_sequencer #(
  parameter int NUM_PADS      = 3,
  parameter int CNT_W         = 12,
  parameter int CHARGE_CYCLES = 16,
  parameter int TIMEOUT       = 4095,
  parameter int THRESH        = 32,
  localparam int IW           = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_PADS-1:0] pad_in,
  output logic [NUM_PADS-1:0] pad_out,
  output logic [NUM_PADS-1:0] pad_oe,
  output logic [NUM_PADS-1:0] btn,
  output logic                sample_valid,
  output logic [IW-1:0]       sample_idx,
  output logic [CNT_W-1:0]    sample_count,
  output logic                calibrated
);

  localparam logic [CNT_W-1:0] CHG_LAST = CNT_W'(CHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_SAT   = CNT_W'(TIMEOUT);
  localparam logic [IW-1:0]    IDX_LAST = IW'(NUM_PADS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHARGE, S_MEASURE, S_EVAL} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        idx;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_PADS-1:0]  sync_p0, sync_p1;
  logic [NUM_PADS-1:0]  sel;
  logic [CNT_W-1:0]     baseline [NUM_PADS];

  // Touch decision with hysteresis; sums are widened by one bit so a
  // baseline near full scale cannot wrap the threshold.
  function automatic logic hyst_next(input logic [CNT_W-1:0] s,
                                     input logic [CNT_W-1:0] b,
                                     input logic             cur);
    logic [CNT_W:0] on_lvl, off_lvl, s_w;
    s_w     = {1'b0, s};
    on_lvl  = {1'b0, b} + (CNT_W+1)'(THRESH);
    off_lvl = {1'b0, b} + (CNT_W+1)'(THRESH / 2);
    if (s_w >= on_lvl)      return 1'b1;
    else if (s_w < off_lvl) return 1'b0;
    else                    return cur;
  endfunction

  assign sel = NUM_PADS'(1) << idx;

  // Two-flop synchroniser for the asynchronous pad levels, runs in all states.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= pad_in;
      sync_p1 <= sync_p0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and pad drive; only the selected pad is ever released.
  always_comb begin
    state_nxt    = state;
    pad_out      = '0;
    pad_oe       = '0;
    sample_valid = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_CHARGE;
      end
      S_CHARGE: begin
        pad_oe  = '1;
        pad_out = sel;
        if (cnt == CHG_LAST) state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        pad_oe = ~sel;
        if (!sync_p1[idx] || cnt == TO_LAST) state_nxt = S_EVAL;
      end
      S_EVAL: begin
        pad_oe       = '1;
        sample_valid = 1'b1;
        state_nxt    = enable ? S_CHARGE : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shared counter, sample capture, baselines, touch flags and pad index.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx          <= '0;
      cnt          <= '0;
      btn          <= '0;
      sample_idx   <= '0;
      sample_count <= '0;
      calibrated   <= 1'b0;
      for (int i = 0; i < NUM_PADS; i++) baseline[i] <= '0;
    end else begin
      case (state)
        S_IDLE: cnt <= '0;
        S_CHARGE: cnt <= (cnt == CHG_LAST) ? '0 : cnt + 1'b1;
        S_MEASURE: begin
          if (!sync_p1[idx]) begin
            sample_count <= cnt;
            sample_idx   <= idx;
            cnt          <= '0;
          end else if (cnt == TO_LAST) begin
            sample_count <= TO_SAT;
            sample_idx   <= idx;
            cnt          <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EVAL: begin
          if (!calibrated) baseline[idx] <= sample_count;
          else             btn[idx] <= hyst_next(sample_count, baseline[idx], btn[idx]);
          if (idx == IDX_LAST) begin
            calibrated <= 1'b1;
            idx        <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
